// File: rtl/iob_nativebridge_arbiter_pkg.sv
// Shared types for the IOb native bridge arbiter: FSM state encoding and grant-width helper.
// Latency: none (declarations only).  Backpressure: n/a.
package iob_nativebridge_arbiter_pkg;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_ACCESS  = 2'd1,
        ST_WAIT_RD = 2'd2
    } nbarb_state_e;

    // Keeps the grant index at least one bit wide even for degenerate configurations.
    function automatic int grant_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/iob_nativebridge_arbiter_rr_picker.sv
// Rotating priority encoder: first set request found walking up from ptr_i, wrapping to 0.
// Latency: purely combinational.  Backpressure: none, the caller holds requests.
module iob_nbarb_rr_picker #(
    parameter int N  = 2,
    parameter int GW = 1
) (
    input  logic [N-1:0]  req_i,
    input  logic [GW-1:0] ptr_i,
    output logic [GW-1:0] win_o,
    output logic          any_o
);

    logic [GW-1:0] cand;
    logic [GW-1:0] win;
    logic          found;

    always_comb begin
        cand  = ptr_i;
        win   = '0;
        found = 1'b0;
        for (int i = 0; i < N; i++) begin
            if (!found && req_i[cand]) begin
                found = 1'b1;
                win   = cand;
            end
            cand = (cand == GW'(N - 1)) ? '0 : cand + 1'b1;
        end
    end

    assign win_o = win;
    assign any_o = found;

endmodule

// File: rtl/iob_nativebridge_arbiter.sv
// Shares one IOb native subordinate between N_MANAGERS managers, one transaction in flight; IOB_NBARB_FIXED_PRIO_EN selects fixed priority.
// Latency: request at cycle t is forwarded at t+1; read data returns combinationally from the subordinate.
// Backpressure: subordinate ready is passed straight to the granted manager; losers see ready=0 and hold valid.
module iob_nativebridge_arbiter
    import iob_nativebridge_arbiter_pkg::*;
#(
    parameter int N_MANAGERS = 2,
    parameter int ADDR_W     = 32,
    parameter int DATA_W     = 32
) (
    input  logic                                    clk_i,
    input  logic                                    rst_i,
    input  logic [N_MANAGERS-1:0]                   m_iob_valid_i,
    input  logic [N_MANAGERS*ADDR_W-1:0]            m_iob_addr_i,
    input  logic [N_MANAGERS*DATA_W-1:0]            m_iob_wdata_i,
    input  logic [N_MANAGERS*(DATA_W/8)-1:0]        m_iob_wstrb_i,
    output logic [N_MANAGERS-1:0]                   m_iob_ready_o,
    output logic [N_MANAGERS-1:0]                   m_iob_rvalid_o,
    output logic [DATA_W-1:0]                       m_iob_rdata_o,
    output logic                                    s_iob_valid_o,
    output logic [ADDR_W-1:0]                       s_iob_addr_o,
    output logic [DATA_W-1:0]                       s_iob_wdata_o,
    output logic [DATA_W/8-1:0]                     s_iob_wstrb_o,
    input  logic                                    s_iob_ready_i,
    input  logic                                    s_iob_rvalid_i,
    input  logic [DATA_W-1:0]                       s_iob_rdata_i,
    output logic [grant_width(N_MANAGERS)-1:0]      grant_o,
    output logic                                    busy_o
);

    localparam int GW = grant_width(N_MANAGERS);
    localparam int SW = DATA_W / 8;

    nbarb_state_e  state_q, state_d;
    logic [GW-1:0] grant_q, grant_d;
    logic          is_read_q, is_read_d;
    logic          done;

    logic [GW-1:0] pick_ptr;
    logic [GW-1:0] pick_idx;
    logic          pick_any;
    logic [SW-1:0] pick_wstrb;

    logic              g_valid;
    logic [ADDR_W-1:0] g_addr;
    logic [DATA_W-1:0] g_wdata;
    logic [SW-1:0]     g_wstrb;

`ifdef IOB_NBARB_FIXED_PRIO_EN
    assign pick_ptr = '0;
`else
    logic [GW-1:0] ptr_q, ptr_d;

    // Search for the next owner starts just past whoever finished last.
    always_comb begin
        ptr_d = ptr_q;
        if (done) begin
            ptr_d = (grant_q == GW'(N_MANAGERS - 1)) ? '0 : grant_q + 1'b1;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            ptr_q <= '0;
        end else begin
            ptr_q <= ptr_d;
        end
    end

    assign pick_ptr = ptr_q;
`endif

    iob_nbarb_rr_picker #(
        .N  (N_MANAGERS),
        .GW (GW)
    ) u_picker (
        .req_i (m_iob_valid_i),
        .ptr_i (pick_ptr),
        .win_o (pick_idx),
        .any_o (pick_any)
    );

    assign pick_wstrb = m_iob_wstrb_i[pick_idx*SW +: SW];

    assign g_valid = m_iob_valid_i[grant_q];
    assign g_addr  = m_iob_addr_i[grant_q*ADDR_W +: ADDR_W];
    assign g_wdata = m_iob_wdata_i[grant_q*DATA_W +: DATA_W];
    assign g_wstrb = m_iob_wstrb_i[grant_q*SW +: SW];

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q   <= ST_IDLE;
            grant_q   <= '0;
            is_read_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            grant_q   <= grant_d;
            is_read_q <= is_read_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        grant_d   = grant_q;
        is_read_d = is_read_q;
        done      = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (pick_any) begin
                    grant_d   = pick_idx;
                    is_read_d = ~|pick_wstrb;
                    state_d   = ST_ACCESS;
                end
            end
            ST_ACCESS: begin
                // A manager dropping valid before acceptance forfeits its slot.
                if (!g_valid) begin
                    state_d = ST_IDLE;
                    done    = 1'b1;
                end else if (s_iob_ready_i) begin
                    if (!is_read_q || s_iob_rvalid_i) begin
                        state_d = ST_IDLE;
                        done    = 1'b1;
                    end else begin
                        state_d = ST_WAIT_RD;
                    end
                end
            end
            ST_WAIT_RD: begin
                if (s_iob_rvalid_i) begin
                    state_d = ST_IDLE;
                    done    = 1'b1;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        s_iob_valid_o  = 1'b0;
        s_iob_addr_o   = '0;
        s_iob_wdata_o  = '0;
        s_iob_wstrb_o  = '0;
        m_iob_ready_o  = '0;
        m_iob_rvalid_o = '0;
        case (state_q)
            ST_ACCESS: begin
                s_iob_valid_o          = g_valid;
                s_iob_addr_o           = g_addr;
                s_iob_wdata_o          = g_wdata;
                s_iob_wstrb_o          = g_wstrb;
                m_iob_ready_o[grant_q] = s_iob_ready_i;
                m_iob_rvalid_o[grant_q] = g_valid & s_iob_ready_i & is_read_q & s_iob_rvalid_i;
            end
            ST_WAIT_RD: begin
                m_iob_rvalid_o[grant_q] = s_iob_rvalid_i;
            end
            default: ;
        endcase
    end

    assign m_iob_rdata_o = s_iob_rdata_i;
    assign grant_o       = grant_q;
    assign busy_o        = (state_q != ST_IDLE);

endmodule

// File: tb/tb_iob_nativebridge_arbiter.sv
// Scoreboard bench: manager/subordinate drivers, a request-order reference model and a decoupled monitor.
module tb_iob_nativebridge_arbiter;

    localparam int N  = 3;
    localparam int AW = 32;
    localparam int DW = 32;
    localparam int SW = DW / 8;

    typedef struct packed {
        logic [AW-1:0] addr;
        logic [DW-1:0] wdata;
        logic [SW-1:0] wstrb;
    } req_t;

    typedef struct packed {
        logic [1:0] mgr;
        req_t       r;
    } exp_t;

    typedef struct packed {
        logic [1:0]    mgr;
        logic [DW-1:0] data;
    } rsp_t;

    logic            clk = 1'b0;
    logic            rst = 1'b1;
    logic [N-1:0]    m_valid = '0;
    logic [N*AW-1:0] m_addr  = '0;
    logic [N*DW-1:0] m_wdata = '0;
    logic [N*SW-1:0] m_wstrb = '0;
    logic [N-1:0]    m_ready, m_rvalid;
    logic [DW-1:0]   m_rdata;
    logic            s_valid;
    logic [AW-1:0]   s_addr;
    logic [DW-1:0]   s_wdata;
    logic [SW-1:0]   s_wstrb;
    logic            s_ready  = 1'b0;
    logic            s_rvalid = 1'b0;
    logic [DW-1:0]   s_rdata  = '0;
    logic [1:0]      grant;
    logic            busy;

    iob_nativebridge_arbiter #(.N_MANAGERS(N), .ADDR_W(AW), .DATA_W(DW)) dut (
        .clk_i(clk), .rst_i(rst),
        .m_iob_valid_i(m_valid), .m_iob_addr_i(m_addr), .m_iob_wdata_i(m_wdata),
        .m_iob_wstrb_i(m_wstrb), .m_iob_ready_o(m_ready), .m_iob_rvalid_o(m_rvalid),
        .m_iob_rdata_o(m_rdata), .s_iob_valid_o(s_valid), .s_iob_addr_o(s_addr),
        .s_iob_wdata_o(s_wdata), .s_iob_wstrb_o(s_wstrb), .s_iob_ready_i(s_ready),
        .s_iob_rvalid_i(s_rvalid), .s_iob_rdata_i(s_rdata), .grant_o(grant), .busy_o(busy)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    req_t mq[N][$];
    exp_t exp_q[$];
    rsp_t exp_rsp[$];
    int   ghist[$];

    int           mptr = 0;
    int           cur_mgr = 0;
    logic [N-1:0] acc = '0;
    bit           arb_chk = 0, zl_chk = 0, sub_rv_real = 0;
    bit           sub_wait = 0;
    int           sub_cnt = 0;
    logic [DW-1:0] sub_data = '0;
    bit           ready_always = 1;
    int           rd_lat = 0;
    bit           use_cfg = 0;
    logic [DW-1:0] rd_cfg = '0;
    int           stray_mode = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Reference arbitration: first requester at or after the pointer, wrapping.
    function automatic int model_pick(input logic [N-1:0] v);
        for (int i = 0; i < N; i++) begin
            if (v[(mptr + i) % N]) return (mptr + i) % N;
        end
        return 0;
    endfunction

    function automatic void model_done(input int m);
`ifndef IOB_NBARB_FIXED_PRIO_EN
        mptr = (m + 1) % N;
`endif
    endfunction

    task automatic issue(input int k, input logic [AW-1:0] a, input logic [DW-1:0] d, input logic [SW-1:0] s);
        req_t r;
        r.addr = a; r.wdata = d; r.wstrb = s;
        mq[k].push_back(r);
    endtask

    function automatic bit pending();
        for (int k = 0; k < N; k++) if (mq[k].size() != 0) return 1;
        return 0;
    endfunction

    // Manager and subordinate drivers.
    always @(posedge clk) begin
        #1;
        for (int k = 0; k < N; k++) begin
            if (acc[k] && mq[k].size() != 0) void'(mq[k].pop_front());
            m_valid[k] = (mq[k].size() != 0);
            m_addr[k*AW +: AW]  = (mq[k].size() != 0) ? mq[k][0].addr  : '0;
            m_wdata[k*DW +: DW] = (mq[k].size() != 0) ? mq[k][0].wdata : '0;
            m_wstrb[k*SW +: SW] = (mq[k].size() != 0) ? mq[k][0].wstrb : '0;
        end
        #1;
        s_ready = 1'b0; s_rvalid = 1'b0; s_rdata = $urandom; sub_rv_real = 0;
        if (!rst) begin
            if (sub_wait) begin
                if (sub_cnt == 0) begin
                    s_rvalid = 1'b1; s_rdata = sub_data; sub_rv_real = 1; sub_wait = 0;
                end else begin
                    sub_cnt--;
                end
            end else if (s_valid) begin
                s_ready = ready_always ? 1'b1 : 1'($urandom_range(0, 1));
                if (s_ready && s_wstrb == '0) begin
                    int lat;
                    rsp_t rs;
                    rs.mgr  = 2'(cur_mgr);
                    rs.data = use_cfg ? rd_cfg : $urandom;
                    exp_rsp.push_back(rs);
                    lat = (rd_lat >= 0) ? rd_lat : $urandom_range(0, 3);
                    if (lat == 0) begin
                        s_rvalid = 1'b1; s_rdata = rs.data; sub_rv_real = 1;
                    end else begin
                        sub_wait = 1; sub_cnt = lat - 1; sub_data = rs.data;
                    end
                end
            end else if (stray_mode == 2 || (stray_mode == 1 && $urandom_range(0, 3) == 0)) begin
                s_rvalid = 1'b1;
            end
        end
    end

    // Monitor / scoreboard.
    always @(negedge clk) begin
        acc = '0;
        if (!rst) begin
            if (arb_chk) begin
                check("arb_latency_s_valid", 64'(s_valid), 64'd1);
                check("arb_grant", 64'(grant), 64'(cur_mgr));
                arb_chk = 0;
            end
            if (zl_chk) begin
                check("zero_lat_back_to_idle", 64'(busy), 64'd0);
                zl_chk = 0;
            end
            if (!busy) check("idle_no_s_valid", 64'(s_valid), 64'd0);
            if (s_valid && s_ready) begin
                if (exp_q.size() == 0) begin
                    checks++; errors++;
                    $display("FAIL unexpected_accept: grant %0d, no request expected", grant);
                end else begin
                    exp_t e;
                    e = exp_q.pop_front();
                    check("acc_grant", 64'(grant), 64'(e.mgr));
                    check("acc_addr", 64'(s_addr), 64'(e.r.addr));
                    check("acc_wdata", 64'(s_wdata), 64'(e.r.wdata));
                    check("acc_wstrb", 64'(s_wstrb), 64'(e.r.wstrb));
                    check("acc_m_ready", 64'(m_ready), 64'd1 << e.mgr);
                    acc[e.mgr] = 1'b1;
                    ghist.push_back(int'(e.mgr));
                    if (e.r.wstrb != '0) model_done(int'(e.mgr));
                    else if (s_rvalid) zl_chk = 1;
                end
            end else begin
                check("no_accept_ready_zero", 64'(m_ready), 64'd0);
            end
            if (sub_rv_real) begin
                if (exp_rsp.size() == 0) begin
                    checks++; errors++;
                    $display("FAIL rsp_queue_empty: m_rvalid %0b", m_rvalid);
                end else begin
                    rsp_t r;
                    r = exp_rsp.pop_front();
                    check("rsp_m_rvalid", 64'(m_rvalid), 64'd1 << r.mgr);
                    check("rsp_rdata", 64'(m_rdata), 64'(r.data));
                    model_done(int'(r.mgr));
                end
            end else begin
                check("no_stray_rvalid", 64'(m_rvalid), 64'd0);
            end
            if (!busy && m_valid != '0) begin
                exp_t e;
                cur_mgr = model_pick(m_valid);
                e.mgr = 2'(cur_mgr);
                e.r   = mq[cur_mgr][0];
                exp_q.push_back(e);
                arb_chk = 1;
            end
        end
    end

    task automatic drain();
        int n = 0;
        while ((pending() || sub_wait || exp_rsp.size() != 0 || busy) && n < 1000) begin
            @(negedge clk);
            n++;
        end
        if (n >= 1000) begin
            checks++; errors++;
            $display("FAIL drain_timeout: transactions still outstanding after %0d cycles", n);
        end
        repeat (2) @(negedge clk);
    endtask

    task automatic do_reset();
        @(posedge clk);
        #3;
        rst = 1'b1;
        sub_wait = 0; exp_q.delete(); exp_rsp.delete();
        mptr = 0; arb_chk = 0; zl_chk = 0;
        repeat (2) @(posedge clk);
        #3;
        rst = 1'b0;
    endtask

    int exp3[4];

    initial begin
`ifdef IOB_NBARB_FIXED_PRIO_EN
        exp3 = '{0, 0, 0, 0};
`else
        exp3 = '{0, 1, 0, 1};
`endif
        repeat (2) @(negedge clk);
        check("reset_grant", 64'(grant), 64'd0);
        check("reset_busy", 64'(busy), 64'd0);
        check("reset_s_valid", 64'(s_valid), 64'd0);
        check("reset_m_ready", 64'(m_ready), 64'd0);
        check("reset_m_rvalid", 64'(m_rvalid), 64'd0);
        @(posedge clk); #3 rst = 1'b0;

        // Single write, then a delayed read on manager 1.
        @(negedge clk); #2 issue(0, 32'h10, 32'hCAFE, 4'hF);
        drain();
        use_cfg = 1; rd_cfg = 32'h1234; rd_lat = 3;
        @(negedge clk); #2 issue(1, 32'h20, 32'h0, 4'h0);
        drain();

        // Contention between m0 and m1.
        ghist.delete();
        @(negedge clk); #2;
        for (int i = 0; i < 4; i++) begin
            issue(0, 32'h100 + 32'(i), 32'hA000 + 32'(i), 4'hF);
            issue(1, 32'h200 + 32'(i), 32'hB000 + 32'(i), 4'h3);
        end
        drain();
        check("contention_count", 64'(ghist.size()), 64'd8);
        for (int i = 0; i < 4 && i < ghist.size(); i++)
            check("contention_grant_order", 64'(ghist[i]), 64'(exp3[i]));

        // Zero-latency read.
        rd_lat = 0; rd_cfg = 32'h5A5A_0001;
        @(negedge clk); #2 issue(2, 32'h30, 32'h0, 4'h0);
        drain();

        // Reset while waiting for read data, then stray rvalid.
        rd_lat = 5;
        @(negedge clk); #2 issue(1, 32'h40, 32'h0, 4'h0);
        for (int i = 0; i < 50 && !sub_wait; i++) @(negedge clk);
        check("wait_rd_reached", 64'(sub_wait), 64'd1);
        do_reset();
        @(negedge clk);
        check("post_reset_grant", 64'(grant), 64'd0);
        check("post_reset_busy", 64'(busy), 64'd0);
        stray_mode = 2;
        repeat (6) @(negedge clk);
        stray_mode = 0;

        // Wrap: last owner 2, then m0 and m2 compete.
        @(negedge clk); #2 issue(2, 32'h50, 32'h1, 4'h1);
        drain();
        ghist.delete();
        @(negedge clk); #2;
        issue(0, 32'h60, 32'h2, 4'h2);
        issue(2, 32'h70, 32'h3, 4'h4);
        drain();
        check("wrap_count", 64'(ghist.size()), 64'd2);
        if (ghist.size() != 0) check("wrap_first_grant", 64'(ghist[0]), 64'd0);

        // Randomised traffic with random ready, read latency and stray rvalid.
        use_cfg = 0; rd_lat = -1; ready_always = 0; stray_mode = 1;
        for (int it = 0; it < 400; it++) begin
            @(negedge clk); #2;
            if ($urandom_range(0, 2) == 0) begin
                int k;
                k = $urandom_range(0, N - 1);
                issue(k, $urandom, $urandom,
                      ($urandom_range(0, 2) == 0) ? 4'h0 : 4'($urandom_range(1, 15)));
            end
        end
        drain();
        check("final_queues_empty", 64'(exp_q.size() + exp_rsp.size()), 64'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not complete");
        $display("Simulation finished: %0d checks, %0d errors", checks, errors + 1);
        $fatal(1);
    end

endmodule
